// File: rtl/reu_xfer_ctrl.sv
// REU DMA transfer sequencer: one byte operation per PHI2 cycle, stalling while BA is low.
// Optional swap transfer type enabled by defining GW4302_SWAP_EN (default: swap completes with no bus cycles).
module reu_xfer_ctrl (
   input  logic       PHI2,
   input  logic       Reset,
   input  logic       ExecuteIn,
   input  logic       FF00DecodeIn,
   input  logic [1:0] XferTypeIn,
   input  logic       Length1,
   input  logic       FF00Write,
   input  logic       BA,
   input  logic       DataMatch,
   output logic       DMAReq,
   output logic       CAEn,
   output logic       CRW,
   output logic       RamOE,
   output logic       RamWE,
   output logic       LatchC,
   output logic       LatchR,
   output logic       NextCA,
   output logic       NextREUA,
   output logic       XferEnd,
   output logic       VerifyErr,
   output logic       Busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_ACQ, S_XFER, S_SWAPA, S_SWAPB, S_END, S_ERR
   } state_t;

   localparam logic [1:0] T_STASH  = 2'b00;
   localparam logic [1:0] T_FETCH  = 2'b01;
   localparam logic [1:0] T_SWAP   = 2'b10;
   localparam logic [1:0] T_VERIFY = 2'b11;

   state_t     state_q, state_d;
   logic [1:0] xtype_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (ExecuteIn) state_d = FF00DecodeIn ? S_ARM : S_ACQ;
         S_ARM: begin
            if (!ExecuteIn)     state_d = S_IDLE;
            else if (FF00Write) state_d = S_ACQ;
         end
`ifdef GW4302_SWAP_EN
         S_ACQ:   if (BA) state_d = (xtype_q == T_SWAP) ? S_SWAPA : S_XFER;
         S_SWAPA: if (BA) state_d = S_SWAPB;
         S_SWAPB: if (BA) state_d = Length1 ? S_END : S_SWAPA;
`else
         // Without swap hardware the command still completes, just with no bus cycles.
         S_ACQ: begin
            if (xtype_q == T_SWAP) state_d = S_END;
            else if (BA)           state_d = S_XFER;
         end
`endif
         S_XFER: begin
            if (BA) begin
               if (xtype_q == T_VERIFY && !DataMatch) state_d = S_ERR;
               else if (Length1)                      state_d = S_END;
            end
         end
         S_END:   state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Transfer type is frozen once the bus is requested.
   always_ff @(negedge PHI2) begin
      if (Reset) begin
         state_q <= S_IDLE;
         xtype_q <= T_STASH;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE || state_q == S_ARM) xtype_q <= XferTypeIn;
      end
   end

   // BA gates the bus and address strobes only; DMAReq holds through stalls.
   always_comb begin
      DMAReq    = 1'b0;
      CAEn      = 1'b0;
      CRW       = 1'b1;
      RamOE     = 1'b0;
      RamWE     = 1'b0;
      LatchC    = 1'b0;
      LatchR    = 1'b0;
      NextCA    = 1'b0;
      NextREUA  = 1'b0;
      XferEnd   = 1'b0;
      VerifyErr = 1'b0;
      Busy      = (state_q != S_IDLE);
      case (state_q)
         S_ACQ: DMAReq = 1'b1;
         S_XFER: begin
            DMAReq = 1'b1;
            if (BA) begin
               CAEn     = 1'b1;
               NextCA   = 1'b1;
               NextREUA = 1'b1;
               case (xtype_q)
                  T_STASH: RamWE = 1'b1;
                  T_FETCH: begin
                     CRW   = 1'b0;
                     RamOE = 1'b1;
                  end
                  default: RamOE = 1'b1;
               endcase
            end
         end
`ifdef GW4302_SWAP_EN
         S_SWAPA: begin
            DMAReq = 1'b1;
            if (BA) begin
               CAEn   = 1'b1;
               RamOE  = 1'b1;
               LatchC = 1'b1;
               LatchR = 1'b1;
            end
         end
         S_SWAPB: begin
            DMAReq = 1'b1;
            if (BA) begin
               CAEn     = 1'b1;
               CRW      = 1'b0;
               RamWE    = 1'b1;
               NextCA   = 1'b1;
               NextREUA = 1'b1;
            end
         end
`endif
         S_END: begin
            DMAReq  = 1'b1;
            XferEnd = 1'b1;
         end
         S_ERR: begin
            DMAReq    = 1'b1;
            VerifyErr = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_reu_xfer_ctrl.sv
// Randomized bench for reu_xfer_ctrl: each command is expanded into a queue of byte operations
// and the expected output vector is derived per PHI2 cycle from that queue and the driven BA.
module tb_reu_xfer_ctrl;

   logic       PHI2 = 1'b1;
   logic       Reset, ExecuteIn, FF00DecodeIn, Length1, FF00Write, BA, DataMatch;
   logic [1:0] XferTypeIn;
   logic       DMAReq, CAEn, CRW, RamOE, RamWE, LatchC, LatchR;
   logic       NextCA, NextREUA, XferEnd, VerifyErr, Busy;

   int vectors     = 0;
   int miscompares = 0;
   bit swap_on;

   reu_xfer_ctrl dut (
      .PHI2(PHI2), .Reset(Reset), .ExecuteIn(ExecuteIn), .FF00DecodeIn(FF00DecodeIn),
      .XferTypeIn(XferTypeIn), .Length1(Length1), .FF00Write(FF00Write), .BA(BA),
      .DataMatch(DataMatch), .DMAReq(DMAReq), .CAEn(CAEn), .CRW(CRW), .RamOE(RamOE),
      .RamWE(RamWE), .LatchC(LatchC), .LatchR(LatchR), .NextCA(NextCA),
      .NextREUA(NextREUA), .XferEnd(XferEnd), .VerifyErr(VerifyErr), .Busy(Busy)
   );

   always #5 PHI2 = ~PHI2;

   wire [11:0] outv = {DMAReq, CAEn, CRW, RamOE, RamWE, LatchC, LatchR,
                       NextCA, NextREUA, XferEnd, VerifyErr, Busy};

   function automatic logic [11:0] mk(input bit dma, cae, crw, oe, we, lc, lr,
                                      nca, nra, xe, ve, busy);
      return {dma, cae, crw, oe, we, lc, lr, nca, nra, xe, ve, busy};
   endfunction

   // I idle, R armed, Q bus held without a byte (acquire or stall), S/F/V byte ops,
   // A/B swap halves, E end of block, X verify error.
   function automatic logic [11:0] expv(input byte c);
      case (c)
         "R":     return mk(0,0,1,0,0,0,0,0,0,0,0,1);
         "Q":     return mk(1,0,1,0,0,0,0,0,0,0,0,1);
         "S":     return mk(1,1,1,0,1,0,0,1,1,0,0,1);
         "F":     return mk(1,1,0,1,0,0,0,1,1,0,0,1);
         "V":     return mk(1,1,1,1,0,0,0,1,1,0,0,1);
         "A":     return mk(1,1,1,1,0,1,1,0,0,0,0,1);
         "B":     return mk(1,1,0,0,1,0,0,1,1,0,0,1);
         "E":     return mk(1,0,1,0,0,0,0,0,0,1,0,1);
         "X":     return mk(1,0,1,0,0,0,0,0,0,0,1,1);
         default: return mk(0,0,1,0,0,0,0,0,0,0,0,0);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
      end
   endtask

   // Inputs are set by the caller just after a falling edge; outputs checked mid-cycle.
   task automatic step(input string tag, input byte c);
      @(posedge PHI2);
      chk(tag, outv, expv(c));
      @(negedge PHI2);
      #1;
   endtask

   task automatic run_xfer(input logic [1:0] typ, input int len, input bit dec, input int bad,
                           input int stall_pct, input int arm_n, input int stall_op,
                           input int stall_n, input int rst_op);
      byte ops[$];
      int  len_r, nstall, forced;
      bit  ba;
      len_r        = len;
      XferTypeIn   = typ;
      FF00DecodeIn = dec;
      ExecuteIn    = 1'b1;
      FF00Write    = 1'b0;
      BA           = 1'b1;
      DataMatch    = 1'b1;
      Length1      = (len_r == 1);
      step("start", "I");
      if (dec) begin
         for (int i = 0; i < arm_n; i++) begin
            BA = 1'($urandom_range(1));
            step("arm", "R");
         end
         FF00Write = 1'b1;
         step("arm_wr", "R");
         FF00Write = 1'b0;
      end
      if (typ == 2'b10 && !swap_on) begin
         BA = 1'($urandom_range(1));
         step("acq", "Q");
      end else begin
         nstall = 0;
         do begin
            ba = (nstall >= 5) ? 1'b1 : ($urandom_range(99) >= stall_pct);
            BA = ba;
            step("acq", "Q");
            nstall++;
         end while (!ba);
      end
      case (typ)
         2'b00: for (int i = 0; i < len; i++) ops.push_back("S");
         2'b01: for (int i = 0; i < len; i++) ops.push_back("F");
         2'b11: for (int i = 0; i < ((bad > 0) ? bad : len); i++) ops.push_back("V");
         default: if (swap_on) for (int i = 0; i < len; i++) begin
            ops.push_back("A");
            ops.push_back("B");
         end
      endcase
      for (int k = 0; k < ops.size(); k++) begin
         forced = (k + 1 == stall_op) ? stall_n : 0;
         nstall = 0;
         forever begin
            ba = (forced > 0) ? 1'b0 :
                 (nstall >= 5) ? 1'b1 : ($urandom_range(99) >= stall_pct);
            BA        = ba;
            Length1   = (len_r == 1);
            DataMatch = ba ? !(ops[k] == "V" && k + 1 == bad) : 1'($urandom_range(1));
            if (!ba) begin
               step("stall", "Q");
               forced--;
               nstall++;
            end else if (rst_op == k + 1) begin
               Reset = 1'b1;
               step("rst_hit", ops[k]);
               Reset     = 1'b0;
               ExecuteIn = 1'b0;
               step("rst_idle", "I");
               return;
            end else begin
               step("byte", ops[k]);
               if (ops[k] != "A") len_r--;
               break;
            end
         end
      end
      BA = 1'($urandom_range(1));
      if (bad > 0) step("verr", "X");
      else         step("xend", "E");
      ExecuteIn = 1'b0;
      step("done", "I");
   endtask

   initial begin
`ifdef GW4302_SWAP_EN
      swap_on = 1'b1;
`else
      swap_on = 1'b0;
`endif
      Reset = 1'b1; ExecuteIn = 1'b0; FF00DecodeIn = 1'b0; XferTypeIn = 2'b00;
      Length1 = 1'b0; FF00Write = 1'b0; BA = 1'b1; DataMatch = 1'b1;
      @(negedge PHI2);
      #1;
      step("reset", "I");
      Reset = 1'b0;

      run_xfer(2'b00, 3, 0, 0, 0, 0, 0, 0, 0);   // stash, no stalls
      run_xfer(2'b01, 2, 0, 0, 0, 0, 2, 4, 0);   // fetch, 4-cycle stall before byte 2
      run_xfer(2'b11, 4, 0, 2, 0, 0, 0, 0, 0);   // verify, mismatch on byte 2
      run_xfer(2'b11, 3, 0, 3, 0, 0, 0, 0, 0);   // verify, mismatch on last byte
      run_xfer(2'b10, 2, 0, 0, 0, 0, 2, 3, 0);   // swap, stall between A and B
      run_xfer(2'b00, 1, 1, 0, 0, 10, 0, 0, 0);  // FF00 decode, long wait in ARM
      run_xfer(2'b00, 5, 0, 0, 0, 0, 0, 0, 3);   // reset mid-stash
      run_xfer(2'b01, 1, 0, 0, 0, 0, 0, 0, 0);   // restart after reset

      // Execute withdrawn while armed returns to idle without requesting the bus.
      XferTypeIn = 2'b00; FF00DecodeIn = 1'b1; ExecuteIn = 1'b1;
      step("arm_go", "I");
      step("arm_wait", "R");
      ExecuteIn = 1'b0;
      step("arm_drop", "R");
      step("arm_idle", "I");

      for (int n = 0; n < 40; n++) begin
         logic [1:0] typ;
         int         len, bad;
         typ = 2'($urandom_range(3));
         len = $urandom_range(6, 1);
         bad = (typ == 2'b11) ? $urandom_range(len, 0) : 0;
         run_xfer(typ, len, 1'($urandom_range(1)), bad, 30, $urandom_range(3), 0, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
